// File: rtl/serial_bit_tx.sv
// serial_bit_tx: parallel-in, serial-out frame transmitter.
// Takes a DATA_W-bit word on a valid/ready handshake and sends it on a single
// registered line as: start bit (0), data bits, optional parity, stop bit (1).
// Every bit is held on the line for CLKS_PER_BIT clocks.
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module serial_bit_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int LSB_FIRST    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state_q;
   logic [DATA_W-1:0] shiftReg_q;
   logic [DATA_W-1:0] shiftReg_d;
   logic [BIT_W-1:0]  bitCnt_q;
   logic [CNT_W-1:0]  cycleCnt_q;
   logic              txOut_q;
   logic              txReady_q;
   logic              nextBit;
   logic              bitEnd;
`ifdef SERIAL_TX_PARITY_EN
   logic              parity_q;
`endif

   // Pick the bit that goes on the line next and the shift register contents
   // once that bit has been consumed; direction depends on LSB_FIRST.
   always_comb begin
      nextBit    = 1'b0;
      shiftReg_d = shiftReg_q;
      if (LSB_FIRST != 0) begin
         nextBit    = shiftReg_q[0];
         shiftReg_d = shiftReg_q >> 1;
      end else begin
         nextBit    = shiftReg_q[DATA_W-1];
         shiftReg_d = shiftReg_q << 1;
      end
   end

   assign bitEnd = (cycleCnt_q == CNT_LAST);

   // Frame sequencer: every output is registered here so the line never has
   // a combinational path back to tx_valid or tx_data. Each transition loads
   // the value the line must show for the whole of the next bit period.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shiftReg_q <= '0;
         bitCnt_q   <= '0;
         cycleCnt_q <= '0;
         txOut_q    <= 1'b1;
         txReady_q  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               cycleCnt_q <= '0;
               bitCnt_q   <= '0;
               if (tx_valid && txReady_q) begin
                  shiftReg_q <= tx_data;
                  state_q    <= START;
                  txOut_q    <= 1'b0;
                  txReady_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                  parity_q   <= ^tx_data;
`endif
               end
            end
            START: begin
               if (bitEnd) begin
                  cycleCnt_q <= '0;
                  bitCnt_q   <= '0;
                  state_q    <= DATA;
                  txOut_q    <= nextBit;
                  shiftReg_q <= shiftReg_d;
               end else begin
                  cycleCnt_q <= cycleCnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (bitEnd) begin
                  cycleCnt_q <= '0;
                  if (bitCnt_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                     state_q <= PARITY;
                     txOut_q <= parity_q;
`else
                     state_q <= STOP;
                     txOut_q <= 1'b1;
`endif
                  end else begin
                     bitCnt_q   <= bitCnt_q + BIT_W'(1);
                     txOut_q    <= nextBit;
                     shiftReg_q <= shiftReg_d;
                  end
               end else begin
                  cycleCnt_q <= cycleCnt_q + CNT_W'(1);
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
               if (bitEnd) begin
                  cycleCnt_q <= '0;
                  state_q    <= STOP;
                  txOut_q    <= 1'b1;
               end else begin
                  cycleCnt_q <= cycleCnt_q + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (bitEnd) begin
                  cycleCnt_q <= '0;
                  bitCnt_q   <= '0;
                  state_q    <= IDLE;
                  txOut_q    <= 1'b1;
                  txReady_q  <= 1'b1;
               end else begin
                  cycleCnt_q <= cycleCnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q    <= IDLE;
               cycleCnt_q <= '0;
               bitCnt_q   <= '0;
               txOut_q    <= 1'b1;
               txReady_q  <= 1'b1;
            end
         endcase
      end
   end

   assign tx_out   = txOut_q;
   assign tx_ready = txReady_q;
   assign busy     = ~txReady_q;

endmodule
